// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO.
package sync_fifo_pkg;

  // Pointer width for a power-of-two depth.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  localparam int unsigned DefWidth = 4;
  localparam int unsigned DefDepth = 8;
  localparam int unsigned DefPtrW  = ptr_width(DefDepth);

endpackage

// File: rtl/sync_fifo_if.sv
// Data/handshake bundle between a FIFO user (master) and the FIFO (slave).
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
);
  logic             en;
  logic             wnr;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic             full;
  logic             empty;

  modport master (output en, wnr, in, input out, full, empty);
  modport slave  (input en, wnr, in, output out, full, empty);
endinterface

// File: rtl/sync_fifo_ram.sv
// DEPTH x WIDTH storage: synchronous write, registered read port.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned PtrW  = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [PtrW-1:0]  i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [PtrW-1:0]  i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Array write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read data register: loads only on a successful read, otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO: pointers, occupancy count and registered full/empty flags.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic     clk,
  input  logic     rst,
  sync_fifo_if.slave bus
);

  localparam int unsigned   PtrW   = ptr_width(DEPTH);
  localparam int unsigned   CntW   = PtrW + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEPTH);

  logic            w_wr;
  logic            w_rd;
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_count;
  logic [CntW-1:0] w_count_d;
  logic            r_full;
  logic            r_empty;
  logic [WIDTH-1:0] w_rdata;

  // wnr selects the single operation, so read and write never coincide.
  assign w_wr = bus.en & bus.wnr & ~r_full;
  assign w_rd = bus.en & ~bus.wnr & ~r_empty;

  // Next occupancy, used for both the count and the registered flags.
  always_comb begin
    w_count_d = r_count;
    if (w_wr) begin
      w_count_d = r_count + CntW'(1);
    end else if (w_rd) begin
      w_count_d = r_count - CntW'(1);
    end
  end

  // Pointer, count and flag state; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_wr) r_wptr <= r_wptr + PtrW'(1);
      if (w_rd) r_rptr <= r_rptr + PtrW'(1);
      r_count <= w_count_d;
      r_full  <= (w_count_d == CntMax);
      r_empty <= (w_count_d == '0);
    end
  end

  sync_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PtrW  (PtrW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_wr),
    .i_waddr (r_wptr),
    .i_wdata (bus.in),
    .i_re    (w_rd),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  assign bus.out   = w_rdata;
  assign bus.full  = r_full;
  assign bus.empty = r_empty;

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo (WIDTH=4, DEPTH=8) with hand-computed expectations.
module tb_sync_fifo;

  typedef struct packed {
    logic [3:0] out;
    logic       full;
    logic       empty;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  bit   pending = 1'b0;
  exp_t exp_q[$];
  logic [3:0] last_out = 4'h0;

  sync_fifo_if #(.WIDTH(4)) bus ();

  sync_fifo #(
    .WIDTH (4),
    .DEPTH (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Issue one operation and queue what the FIFO must show after the edge.
  task automatic op(input bit e, input bit w, input logic [3:0] d,
                    input logic [3:0] eo, input bit ef, input bit ee);
    exp_t x;
    bus.en  = e;
    bus.wnr = w;
    bus.in  = d;
    x.out   = eo;
    x.full  = ef;
    x.empty = ee;
    exp_q.push_back(x);
    last_out = eo;
    pending  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] d, input bit ef, input bit ee);
    op(1'b1, 1'b1, d, last_out, ef, ee);
  endtask

  task automatic rd(input logic [3:0] eo, input bit ef, input bit ee);
    op(1'b1, 1'b0, 4'h0, eo, ef, ee);
  endtask

  // Monitor: after every issued edge, compare outputs against the queue head.
  always @(posedge clk) begin
    if (pending) begin
      exp_t x;
      #2;
      if (exp_q.size() == 0) begin
        check("scoreboard_underrun", 32'd1, 32'd0);
      end else begin
        x = exp_q.pop_front();
        check("out",   32'(bus.out),   32'(x.out));
        check("full",  32'(bus.full),  32'(x.full));
        check("empty", 32'(bus.empty), 32'(x.empty));
      end
    end
  end

  initial begin
    bus.en  = 1'b0;
    bus.wnr = 1'b0;
    bus.in  = 4'h0;

    // Reset with en=0.
    #12;
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full",  32'(bus.full),  32'd0);
    check("rst_out",   32'(bus.out),   32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fill 0..7: empty drops after the first, full only after the eighth.
    for (int i = 0; i < 8; i++) wr(4'(i), i == 7, 1'b0);
    // Overflow write is dropped.
    wr(4'hF, 1'b1, 1'b0);
    // Drain yields 0..7.
    for (int i = 0; i < 8; i++) rd(4'(i), 1'b0, i == 7);
    // Underflow read: out holds 7, flags unchanged.
    rd(4'h7, 1'b0, 1'b1);

    // Wrap: write 1..5, read 1..3, write 6..B (full), read 4..B.
    for (int i = 1; i <= 5; i++) wr(4'(i), 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) rd(4'(i), 1'b0, 1'b0);
    for (int i = 6; i <= 11; i++) wr(4'(i), i == 11, 1'b0);
    for (int i = 4; i <= 11; i++) rd(4'(i), 1'b0, i == 11);

    // Enable low: wnr and in toggle, nothing changes.
    wr(4'h3, 1'b0, 1'b0);
    wr(4'h6, 1'b0, 1'b0);
    wr(4'h9, 1'b0, 1'b0);
    op(1'b0, 1'b1, 4'hA, 4'hB, 1'b0, 1'b0);
    op(1'b0, 1'b0, 4'h5, 4'hB, 1'b0, 1'b0);
    op(1'b0, 1'b1, 4'hC, 4'hB, 1'b0, 1'b0);
    rd(4'h3, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle with 2 entries stored.
    pending = 1'b0;
    bus.en  = 1'b0;
    #3;
    check("pre_rst_empty", 32'(bus.empty), 32'd0);
    rst = 1'b1;
    #1;
    check("async_empty", 32'(bus.empty), 32'd1);
    check("async_full",  32'(bus.full),  32'd0);
    check("async_out",   32'(bus.out),   32'd0);
    #2;
    rst = 1'b0;
    last_out = 4'h0;
    @(posedge clk);
    #1;

    // Resume: old entries are gone, new data flows.
    wr(4'hD, 1'b0, 1'b0);
    rd(4'hD, 1'b0, 1'b1);
    rd(4'hD, 1'b0, 1'b1);

    pending = 1'b0;
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    #3;
    check("scoreboard_left", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
